control_sequencer: RTL and testbench

//   Parametrised successor to the fixed 2-bit-to-8-bit control decoder. It holds a writable

---
 rtl/control_sequencer_if.sv | 42 ++++
 rtl/control_sequencer.sv | 137 +++++++++++++
 tb/tb_control_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control sequencer bus: table write port, sequence launch/abort controls and the
// registered pattern outputs. The optional pause input exists only when
// CTRL_SEQ_PAUSE_EN is defined.
interface control_sequencer_if #(
  parameter int OUT_W   = 8,
  parameter int IDX_W   = 2,
  parameter int DWELL_W = 8
);
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [OUT_W-1:0]   wr_pattern;
  logic [DWELL_W-1:0] wr_dwell;
  logic [IDX_W-1:0]   last_idx;
  logic               loop_mode;
  logic               start;
  logic               stop;
`ifdef CTRL_SEQ_PAUSE_EN
  logic               pause;
`endif
  logic [OUT_W-1:0]   out;
  logic [IDX_W-1:0]   step;
  logic               busy;
  logic               done;

  // Driver side: owns the table writes and launch controls, observes the outputs.
  modport master (
`ifdef CTRL_SEQ_PAUSE_EN
    output pause,
`endif
    output wr_en, wr_idx, wr_pattern, wr_dwell, last_idx, loop_mode, start, stop,
    input  out, step, busy, done
  );

  // Sequencer side.
  modport slave (
`ifdef CTRL_SEQ_PAUSE_EN
    input  pause,
`endif
    input  wr_en, wr_idx, wr_pattern, wr_dwell, last_idx, loop_mode, start, stop,
    output out, step, busy, done
  );
endinterface

// File: rtl/control_sequencer.sv
// Table-driven output pattern sequencer. Holds STEPS {pattern, dwell} entries and
// plays entries 0..last_idx, each for dwell+1 cycles, once or in a loop.
// Optional feature: define CTRL_SEQ_PAUSE_EN to add a pause input that freezes a
// running sequence; without it the sequencer behaves as if pause were held low.
module control_sequencer #(
  parameter int               OUT_W    = 8,
  parameter int               STEPS    = 4,
  parameter int               IDX_W    = 2,
  parameter int               DWELL_W  = 8,
  parameter logic [OUT_W-1:0] IDLE_PAT = '0
) (
  input logic               clk,
  input logic               rst_n,
  control_sequencer_if.slave bus
);

  typedef enum logic { S_IDLE = 1'b0, S_RUN = 1'b1 } state_t;

  state_t             state_q;
  logic [OUT_W-1:0]   out_q;
  logic [IDX_W-1:0]   step_q;
  logic               busy_q;
  logic               done_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [IDX_W-1:0]   last_q;
  logic               loop_q;

  logic [OUT_W-1:0]   pat_q   [STEPS];
  logic [DWELL_W-1:0] dwell_q [STEPS];

  logic               pause_d;
  logic               wr_ok_d;
  logic [IDX_W-1:0]   last_d;
  logic [IDX_W-1:0]   next_idx_d;

  // Power-up table contents carried over from the fixed decoder it replaces.
  function automatic logic [OUT_W-1:0] reset_pat(input int k);
    case (k)
      0:       reset_pat = OUT_W'(8'h0B);
      1:       reset_pat = OUT_W'(8'h66);
      2:       reset_pat = OUT_W'(8'h14);
      3:       reset_pat = OUT_W'(8'h80);
      default: reset_pat = '0;
    endcase
  endfunction

`ifdef CTRL_SEQ_PAUSE_EN
  assign pause_d = bus.pause;
`else
  assign pause_d = 1'b0;
`endif

  // Out-of-range writes are dropped; out-of-range final steps clamp to the last entry.
  always_comb begin
    wr_ok_d    = bus.wr_en && (int'(bus.wr_idx) < STEPS);
    last_d     = (int'(bus.last_idx) >= STEPS) ? IDX_W'(STEPS - 1) : bus.last_idx;
    next_idx_d = (step_q == last_q) ? '0 : step_q + IDX_W'(1);
  end

  // Pattern/dwell table; a write lands on the next edge, so a same-cycle step entry sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STEPS; k++) begin
        pat_q[k]   <= reset_pat(k);
        dwell_q[k] <= '0;
      end
    end else if (wr_ok_d) begin
      pat_q[bus.wr_idx]   <= bus.wr_pattern;
      dwell_q[bus.wr_idx] <= bus.wr_dwell;
    end
  end

  // Sequencer FSM with registered outputs; out and cnt load only on step entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= IDLE_PAT;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.stop) begin
            state_q <= S_RUN;
            step_q  <= '0;
            out_q   <= pat_q[0];
            cnt_q   <= dwell_q[0];
            busy_q  <= 1'b1;
            last_q  <= last_d;
            loop_q  <= bus.loop_mode;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state_q <= S_IDLE;
            out_q   <= IDLE_PAT;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (!pause_d) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DWELL_W'(1);
            end else if ((step_q != last_q) || loop_q) begin
              step_q <= next_idx_d;
              out_q  <= pat_q[next_idx_d];
              cnt_q  <= dwell_q[next_idx_d];
            end else begin
              state_q <= S_IDLE;
              out_q   <= IDLE_PAT;
              step_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          out_q   <= IDLE_PAT;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.step = step_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (STEPS=4 and STEPS=3) share one
// stimulus stream; a cycle-plan reference model queues expected outputs and a
// monitor compares them on the falling edge.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en = 0;
  logic [1:0] wr_idx = 0;
  logic [7:0] wr_pattern = 0;
  logic [7:0] wr_dwell = 0;
  logic [1:0] last_idx = 0;
  logic       loop_mode = 0;
  logic       start = 0;
  logic       stop = 0;
  logic       pause = 0;

  control_sequencer_if #(.OUT_W(8), .IDX_W(2), .DWELL_W(8)) if0 ();
  control_sequencer_if #(.OUT_W(8), .IDX_W(2), .DWELL_W(8)) if1 ();

  assign if0.wr_en = wr_en;           assign if1.wr_en = wr_en;
  assign if0.wr_idx = wr_idx;         assign if1.wr_idx = wr_idx;
  assign if0.wr_pattern = wr_pattern; assign if1.wr_pattern = wr_pattern;
  assign if0.wr_dwell = wr_dwell;     assign if1.wr_dwell = wr_dwell;
  assign if0.last_idx = last_idx;     assign if1.last_idx = last_idx;
  assign if0.loop_mode = loop_mode;   assign if1.loop_mode = loop_mode;
  assign if0.start = start;           assign if1.start = start;
  assign if0.stop = stop;             assign if1.stop = stop;
`ifdef CTRL_SEQ_PAUSE_EN
  assign if0.pause = pause;           assign if1.pause = pause;
`endif

  control_sequencer #(.OUT_W(8), .STEPS(4), .IDX_W(2), .DWELL_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  control_sequencer #(.OUT_W(8), .STEPS(3), .IDX_W(2), .DWELL_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct packed {
    logic [7:0] out;
    logic [1:0] step;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [7:0] pat;
    logic [1:0] step;
  } slot_t;

  int compared = 0;
  int mismatched = 0;

  // Reference model: while running, plan[] holds one slot per remaining cycle of the current step.
  exp_t       exp_q [2][$];
  slot_t      plan  [2][$];
  bit         run_m [2];
  bit         loop_m[2];
  logic [1:0] cur_m [2];
  logic [1:0] last_m[2];
  exp_t       hold_m[2];
  logic [7:0] mpat  [2][4];
  logic [7:0] mdw   [2][4];

  function automatic int nsteps(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic exp_t idle_e(input bit d);
    exp_t e;
    e.out = 8'h00; e.step = 2'd0; e.busy = 1'b0; e.done = d;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run_m[i] = 0; loop_m[i] = 0; cur_m[i] = 0; last_m[i] = 0;
      hold_m[i] = idle_e(0);
      plan[i].delete();
      exp_q[i].delete();
      mpat[i][0] = 8'h0B; mpat[i][1] = 8'h66; mpat[i][2] = 8'h14; mpat[i][3] = 8'h80;
      for (int k = 0; k < 4; k++) mdw[i][k] = 8'h00;
    end
  endtask

  task automatic enter(input int i, input logic [1:0] k);
    slot_t s;
    cur_m[i] = k;
    s.pat = mpat[i][k];
    s.step = k;
    for (int n = 0; n <= int'(mdw[i][k]); n++) plan[i].push_back(s);
  endtask

  task automatic model_step(input int i);
    exp_t  e;
    slot_t s;
    e = idle_e(0);
    if (!run_m[i]) begin
      if (start && !stop) begin
        run_m[i]  = 1;
        last_m[i] = (int'(last_idx) >= nsteps(i)) ? 2'(nsteps(i) - 1) : last_idx;
        loop_m[i] = loop_mode;
        plan[i].delete();
        enter(i, 2'd0);
        s = plan[i].pop_front();
        e.out = s.pat; e.step = s.step; e.busy = 1'b1; e.done = 1'b0;
      end
    end else if (stop) begin
      run_m[i] = 0;
      plan[i].delete();
    end else if (pause) begin
      e = hold_m[i];
    end else begin
      if (plan[i].size() == 0) begin
        if (cur_m[i] != last_m[i]) enter(i, 2'(cur_m[i] + 2'd1));
        else if (loop_m[i]) enter(i, 2'd0);
        else run_m[i] = 0;
      end
      if (run_m[i]) begin
        s = plan[i].pop_front();
        e.out = s.pat; e.step = s.step; e.busy = 1'b1; e.done = 1'b0;
      end else begin
        e = idle_e(1);
      end
    end
    hold_m[i] = e;
    exp_q[i].push_back(e);
    if (wr_en && int'(wr_idx) < nsteps(i)) begin
      mpat[i][wr_idx] = wr_pattern;
      mdw[i][wr_idx]  = wr_dwell;
    end
  endtask

  task automatic check(input string name, input bit ok, input string got, input string want);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  function automatic exp_t actual(input int i);
    exp_t a;
    if (i == 0) begin a.out = if0.out; a.step = if0.step; a.busy = if0.busy; a.done = if0.done; end
    else        begin a.out = if1.out; a.step = if1.step; a.busy = if1.busy; a.done = if1.done; end
    return a;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("out=%02h step=%0d busy=%0b done=%0b", e.out, e.step, e.busy, e.done);
  endfunction

  task automatic check_reset(input string tag);
    exp_t a;
    for (int i = 0; i < 2; i++) begin
      a = actual(i);
      check($sformatf("%s_inst%0d", tag, i), a == idle_e(0), fmt(a), fmt(idle_e(0)));
    end
  endtask

  // Monitor: one expected entry per instance per clock, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e, a;
    bit   ok;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          a = actual(i);
          ok = (a.out == e.out) && (a.busy == e.busy) && (a.done == e.done) &&
               (!e.busy || (a.step == e.step));
          check($sformatf("cycle_inst%0d", i), ok, fmt(a), fmt(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic clr();
    wr_en = 0; start = 0; stop = 0;
  endtask

  task automatic write(input logic [1:0] idx, input logic [7:0] p, input logic [7:0] d);
    wr_en = 1; wr_idx = idx; wr_pattern = p; wr_dwell = d;
    tick();
    wr_en = 0;
  endtask

  task automatic launch(input logic [1:0] l, input bit lp);
    last_idx = l; loop_mode = lp; start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_step(input logic [1:0] k, input string name);
    bit found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (run_m[0] && cur_m[0] == k) found = 1;
      else tick();
    end
    check(name, found, "step not reached", $sformatf("step %0d within 40 cycles", k));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1;
    @(negedge clk);

    // Default table, one-shot over all four steps.
    launch(2'd3, 1'b0);
    repeat (6) tick();

    // Longer dwell on step 1, looping; then rewrite step 1 while it is active.
    write(2'd1, 8'h66, 8'd2);
    launch(2'd3, 1'b1);
    repeat (12) tick();
    wait_step(2'd1, "reach_step1");
    write(2'd1, 8'h5A, 8'd0);
    repeat (14) tick();
    stop = 1; tick(); stop = 0;
    tick();

    // Stop together with start mid-run, then an immediate restart.
    launch(2'd3, 1'b0);
    tick(); tick();
    start = 1; stop = 1; tick();
    stop = 0; tick();
    start = 0;
    repeat (5) tick();
    stop = 1; tick(); stop = 0;

    // Out-of-range last index and write: clamped / ignored on the 3-entry instance.
    write(2'd3, 8'hAA, 8'd1);
    launch(2'd3, 1'b0);
    repeat (12) tick();

`ifdef CTRL_SEQ_PAUSE_EN
    // Pause during a dwell-3 step.
    write(2'd2, 8'h14, 8'd3);
    launch(2'd3, 1'b0);
    wait_step(2'd2, "reach_step2");
    tick();
    pause = 1; repeat (5) tick(); pause = 0;
    repeat (10) tick();
    start = 1; pause = 1; tick(); start = 0;
    repeat (3) tick();
    stop = 1; tick(); stop = 0; pause = 0;
    tick();
`endif

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      clr();
      if ($urandom_range(0, 7) == 0) begin
        wr_en = 1; wr_idx = 2'($urandom_range(0, 3));
        wr_pattern = 8'($urandom); wr_dwell = 8'($urandom_range(0, 3));
      end
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      last_idx = 2'($urandom_range(0, 3));
      loop_mode = 1'($urandom_range(0, 1));
`ifdef CTRL_SEQ_PAUSE_EN
      pause = ($urandom_range(0, 4) == 0);
`endif
      tick();
    end
    clr();
    pause = 0;
    stop = 1; tick(); stop = 0;

    // Asynchronous reset in the middle of a looping run restores the table too.
    launch(2'd3, 1'b1);
    repeat (3) tick();
    #2;
    rst_n = 0;
    #1;
    check_reset("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    launch(2'd3, 1'b0);
    repeat (6) tick();

    #2;
    check("drain_inst0", exp_q[0].size() == 0, $sformatf("%0d pending", exp_q[0].size()), "0 pending");
    check("drain_inst1", exp_q[1].size() == 0, $sformatf("%0d pending", exp_q[1].size()), "0 pending");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
